// File: rtl/envase_pkg.sv
// Shared definitions for the bottling-line counter: cork FSM states, BCD helpers, 7-segment patterns.
// Pure declarations; no latency or backpressure of its own.
package envase_pkg;

    typedef logic [1:0] estado_t;
    localparam estado_t ST_NORMAL   = 2'd0;
    localparam estado_t ST_RECARGA  = 2'd1;
    localparam estado_t ST_ESGOTADO = 2'd2;

    localparam logic [1:0] SEL_DUZ_DEZ = 2'd0;
    localparam logic [1:0] SEL_DUZ_UNI = 2'd1;
    localparam logic [1:0] SEL_ROL_DEZ = 2'd2;
    localparam logic [1:0] SEL_ROL_UNI = 2'd3;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
        case (n)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return 7'h00;
        endcase
    endfunction

    // Two-digit BCD increment, 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {(v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/sincroniza_borda.sv
// Two-flop synchroniser plus delay flop; one-cycle pulse per rising edge of an async level input.
// Latency: pulse is high in the cycle after the second edge that sees the input high; no backpressure.
module sincroniza_borda (
    input  logic clk,
    input  logic rst,
    input  logic ent,
    output logic pulso
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic dly_q, dly_d;

    always_comb begin
        s1_d  = ent;
        s2_d  = s1_q;
        dly_d = s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            dly_q <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            dly_q <= dly_d;
        end
    end

    assign pulso = s2_q & ~dly_q;

endmodule

// File: rtl/envase_contador_param.sv
// Bottle dozens / cork stock counter with timed auto-refill and 4-digit multiplexed display.
// Latency: counters move 2 edges after a switch is first sampled high; backpressure: none, one event per press.
module envase_contador_param
    import envase_pkg::*;
#(
    parameter int ROLHA_MAX      = 20,
    parameter int ROLHA_MIN      = 5,
    parameter int RECARGAS_MAX   = 7,
    parameter int RECARGA_CICLOS = 16,
    parameter int DUZIA          = 12,
    parameter int REFRESH_DIV    = 8192
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ch_rolha,
    input  logic       ch_garrafa,
    input  logic       ch_zera,
    output logic [6:0] seg,
    output logic [3:0] dig,
    output logic [7:0] duzias_bcd,
    output logic [7:0] rolhas_bcd,
    output logic [3:0] recargas_rest,
    output logic       rolha_vazia,
    output logic       recarregando,
    output logic       estouro
);

    localparam int SW = $clog2(DUZIA);
    localparam int TW = $clog2(RECARGA_CICLOS + 1);
    localparam int RW = $clog2(REFRESH_DIV);

    localparam logic [7:0]    MAX_BCD = to_bcd(ROLHA_MAX);
    localparam logic [7:0]    MIN_BCD = to_bcd(ROLHA_MIN);
    localparam logic [3:0]    REC_INI = 4'(RECARGAS_MAX);
    localparam logic [SW-1:0] SUB_ULT = SW'(DUZIA - 1);
    localparam logic [TW-1:0] TMR_INI = TW'(RECARGA_CICLOS - 1);
    localparam logic [RW-1:0] REF_ULT = RW'(REFRESH_DIV - 1);

    logic rolha_pls, garrafa_pls, zera_pls;

    sincroniza_borda u_sinc_rolha   (.clk(clk), .rst(rst), .ent(ch_rolha),   .pulso(rolha_pls));
    sincroniza_borda u_sinc_garrafa (.clk(clk), .rst(rst), .ent(ch_garrafa), .pulso(garrafa_pls));
    sincroniza_borda u_sinc_zera    (.clk(clk), .rst(rst), .ent(ch_zera),    .pulso(zera_pls));

    estado_t       estado_q,   estado_d;
    logic [7:0]    rolhas_q,   rolhas_d;
    logic [3:0]    recargas_q, recargas_d;
    logic [TW-1:0] timer_q,    timer_d;
    logic [SW-1:0] sub_q,      sub_d;
    logic [7:0]    duzias_q,   duzias_d;
    logic          estouro_q,  estouro_d;
    logic [RW-1:0] ref_q,      ref_d;
    logic [1:0]    sel_q,      sel_d;
    logic [6:0]    seg_q,      seg_d;
    logic [7:0]    rolha_dec;
    logic [3:0]    nib;

    always_comb begin
        estado_d   = estado_q;
        rolhas_d   = rolhas_q;
        recargas_d = recargas_q;
        timer_d    = timer_q;
        sub_d      = sub_q;
        duzias_d   = duzias_q;
        estouro_d  = estouro_q;
        rolha_dec  = bcd_dec(rolhas_q);

        if (zera_pls) begin
            estado_d   = ST_NORMAL;
            rolhas_d   = MAX_BCD;
            recargas_d = REC_INI;
            timer_d    = '0;
            sub_d      = '0;
            duzias_d   = 8'h00;
            estouro_d  = 1'b0;
        end else begin
            case (estado_q)
                ST_NORMAL: begin
                    if (rolha_pls && rolhas_q != 8'h00) begin
                        rolhas_d = rolha_dec;
                        if (rolha_dec == MIN_BCD) begin
                            if (recargas_q != 4'd0) begin
                                estado_d   = ST_RECARGA;
                                recargas_d = recargas_q - 4'd1;
                                timer_d    = TMR_INI;
                            end else begin
                                estado_d = ST_ESGOTADO;
                            end
                        end
                    end
                end
                // Cork presses are dropped for the whole refill window.
                ST_RECARGA: begin
                    if (timer_q == '0) begin
                        rolhas_d = MAX_BCD;
                        estado_d = ST_NORMAL;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_ESGOTADO: begin
                    if (rolha_pls && rolhas_q != 8'h00)
                        rolhas_d = rolha_dec;
                end
                default: estado_d = ST_NORMAL;
            endcase

            if (garrafa_pls) begin
                if (sub_q == SUB_ULT) begin
                    sub_d    = '0;
                    duzias_d = bcd_inc(duzias_q);
                    if (duzias_q == 8'h99)
                        estouro_d = 1'b1;
                end else begin
                    sub_d = sub_q + 1'b1;
                end
            end
        end

        ref_d = (ref_q == REF_ULT) ? '0 : ref_q + 1'b1;
        sel_d = (ref_q == REF_ULT) ? sel_q + 2'd1 : sel_q;

        // Decode from next-state values so seg and dig always describe the same digit.
        nib = 4'd0;
        case (sel_d)
            SEL_DUZ_DEZ: nib = duzias_d[7:4];
            SEL_DUZ_UNI: nib = duzias_d[3:0];
            SEL_ROL_DEZ: nib = rolhas_d[7:4];
            SEL_ROL_UNI: nib = rolhas_d[3:0];
            default:     nib = 4'd0;
        endcase
        seg_d = bcd_to_seg(nib);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q   <= ST_NORMAL;
            rolhas_q   <= MAX_BCD;
            recargas_q <= REC_INI;
            timer_q    <= '0;
            sub_q      <= '0;
            duzias_q   <= 8'h00;
            estouro_q  <= 1'b0;
            ref_q      <= '0;
            sel_q      <= 2'd0;
            seg_q      <= SEG_0;
        end else begin
            estado_q   <= estado_d;
            rolhas_q   <= rolhas_d;
            recargas_q <= recargas_d;
            timer_q    <= timer_d;
            sub_q      <= sub_d;
            duzias_q   <= duzias_d;
            estouro_q  <= estouro_d;
            ref_q      <= ref_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
        end
    end

    assign seg           = seg_q;
    assign dig           = ~(4'b0001 << sel_q);
    assign duzias_bcd    = duzias_q;
    assign rolhas_bcd    = rolhas_q;
    assign recargas_rest = recargas_q;
    assign rolha_vazia   = (rolhas_q == 8'h00);
    assign recarregando  = (estado_q == ST_RECARGA);
    assign estouro       = estouro_q;

endmodule

// File: tb/tb_envase_contador_param.sv
// Bench for envase_contador_param: vector table, hand sequences for refill/clear/reset/display,
// and random switch activity against an event-level reference model checked every cycle.
module tb_envase_contador_param;

    localparam int RMAX = 20;
    localparam int RMIN = 5;
    localparam int NREC = 1;
    localparam int RCIC = 4;
    localparam int DZ   = 12;
    localparam int RDIV = 4;

    localparam int OP_ROL  = 0;
    localparam int OP_GAR  = 1;
    localparam int OP_ZERA = 2;
    localparam int OP_HOLD = 3;

    logic       clk = 1'b0;
    logic       rst, ch_rolha, ch_garrafa, ch_zera;
    logic [6:0] seg;
    logic [3:0] dig;
    logic [7:0] duzias_bcd, rolhas_bcd;
    logic [3:0] recargas_rest;
    logic       rolha_vazia, recarregando, estouro;

    always #5 clk = ~clk;

    envase_contador_param #(
        .ROLHA_MAX(RMAX), .ROLHA_MIN(RMIN), .RECARGAS_MAX(NREC),
        .RECARGA_CICLOS(RCIC), .DUZIA(DZ), .REFRESH_DIV(RDIV)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_rolha(ch_rolha), .ch_garrafa(ch_garrafa), .ch_zera(ch_zera),
        .seg(seg), .dig(dig),
        .duzias_bcd(duzias_bcd), .rolhas_bcd(rolhas_bcd),
        .recargas_rest(recargas_rest), .rolha_vazia(rolha_vazia),
        .recarregando(recarregando), .estouro(estouro)
    );

    int n_chk = 0;
    int n_ok  = 0;

    task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got %0h, expected %0h", nome, got, exp);
    endtask

    // Reference model: plain integers, one event per rising edge of each switch.
    int       m_rol, m_rec, m_refill, m_sub, m_duz, m_cyc;
    bit       m_est;
    bit [2:0] hr, hg, hz;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic m_clear();
        m_rol = RMAX; m_rec = NREC; m_refill = 0; m_sub = 0; m_duz = 0; m_est = 0;
    endtask

    task automatic m_full_reset();
        m_clear();
        m_cyc = 0; hr = '0; hg = '0; hz = '0;
    endtask

    // Events land two edges after the first edge that samples the switch high.
    task automatic m_edge();
        bit pr, pg, pz;
        pr = hr[1] & ~hr[2];
        pg = hg[1] & ~hg[2];
        pz = hz[1] & ~hz[2];
        hr = {hr[1:0], ch_rolha};
        hg = {hg[1:0], ch_garrafa};
        hz = {hz[1:0], ch_zera};
        if (pz) begin
            m_clear();
        end else begin
            if (m_refill > 0) begin
                m_refill--;
                if (m_refill == 0) m_rol = RMAX;
            end else if (pr && m_rol > 0) begin
                m_rol--;
                if (m_rol == RMIN && m_rec > 0) begin
                    m_rec--;
                    m_refill = RCIC;
                end
            end
            if (pg) begin
                m_sub++;
                if (m_sub == DZ) begin
                    m_sub = 0;
                    m_duz++;
                    if (m_duz == 100) begin m_duz = 0; m_est = 1; end
                end
            end
        end
        m_cyc++;
    endtask

    function automatic logic [33:0] m_expect();
        int       s, d;
        logic [3:0] dg;
        s = (m_cyc / RDIV) % 4;
        case (s)
            0:       d = m_duz / 10;
            1:       d = m_duz % 10;
            2:       d = m_rol / 10;
            default: d = m_rol % 10;
        endcase
        dg = ~(4'b0001 << s);
        return {seg_of(d), dg, bcd(m_duz), bcd(m_rol), 4'(m_rec),
                (m_rol == 0), (m_refill > 0), m_est};
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst) m_edge();
        @(negedge clk);
        if (!rst)
            chk("model", 64'({seg, dig, duzias_bcd, rolhas_bcd, recargas_rest,
                              rolha_vazia, recarregando, estouro}), 64'(m_expect()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_sw(input int sw, input logic v);
        case (sw)
            OP_ROL:  ch_rolha   = v;
            OP_GAR:  ch_garrafa = v;
            default: ch_zera    = v;
        endcase
    endtask

    task automatic press(input int sw, input int n);
        for (int i = 0; i < n; i++) begin
            set_sw(sw, 1'b1); step();
            set_sw(sw, 1'b0); step();
        end
    endtask

    task automatic wait_refill();
        int n = 0;
        while (!recarregando && n < 12) begin step(); n++; end
    endtask

    typedef struct {
        int         op;
        int         n;
        logic [7:0] rol;
        logic [7:0] duz;
        logic [3:0] rec;
        logic       vaz;
        logic       est;
    } vec_t;

    vec_t vt [11];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : main
        int n;
        logic [3:0] dig_exp [4];
        logic [6:0] seg_exp [4];

        vt[0]  = '{OP_ROL,  14,   8'h06, 8'h00, 4'd1, 1'b0, 1'b0};
        vt[1]  = '{OP_ROL,  15,   8'h05, 8'h00, 4'd0, 1'b0, 1'b0};
        vt[2]  = '{OP_ROL,  5,    8'h00, 8'h00, 4'd0, 1'b1, 1'b0};
        vt[3]  = '{OP_ROL,  3,    8'h00, 8'h00, 4'd0, 1'b1, 1'b0};
        vt[4]  = '{OP_GAR,  12,   8'h00, 8'h01, 4'd0, 1'b1, 1'b0};
        vt[5]  = '{OP_HOLD, 50,   8'h00, 8'h01, 4'd0, 1'b1, 1'b0};
        vt[6]  = '{OP_GAR,  10,   8'h00, 8'h01, 4'd0, 1'b1, 1'b0};
        vt[7]  = '{OP_GAR,  1,    8'h00, 8'h02, 4'd0, 1'b1, 1'b0};
        vt[8]  = '{OP_GAR,  1164, 8'h00, 8'h99, 4'd0, 1'b1, 1'b0};
        vt[9]  = '{OP_GAR,  11,   8'h00, 8'h99, 4'd0, 1'b1, 1'b0};
        vt[10] = '{OP_GAR,  1,    8'h00, 8'h00, 4'd0, 1'b1, 1'b1};

        rst = 1'b1; ch_rolha = 1'b0; ch_garrafa = 1'b0; ch_zera = 1'b0;
        m_full_reset();
        repeat (2) @(negedge clk);
        chk("reset rolhas",   64'(rolhas_bcd),    64'(8'h20));
        chk("reset duzias",   64'(duzias_bcd),    64'(8'h00));
        chk("reset recargas", 64'(recargas_rest), 64'(4'd1));
        chk("reset dig",      64'(dig),           64'(4'b1110));
        chk("reset seg",      64'(seg),           64'(7'h3F));
        chk("reset flags",    64'({rolha_vazia, recarregando, estouro}), 64'(3'b000));
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            if (i == 1) begin
                // Refill: entry on the decrement to MIN, exactly RCIC cycles, presses ignored.
                press(OP_ROL, 1);
                wait_refill();
                chk("refill entry",  64'(recarregando), 64'(1'b1));
                chk("refill at min", 64'(rolhas_bcd),   64'(8'h05));
                ch_rolha = 1'b1;
                n = 0;
                while (recarregando && n < 20) begin
                    if (n == RCIC - 1) chk("refill ignores press", 64'(rolhas_bcd), 64'(8'h05));
                    n++;
                    step();
                    ch_rolha = 1'b0;
                end
                chk("refill length", 64'(n), 64'(RCIC));
                idle(4);
                chk("refill reload",   64'(rolhas_bcd),    64'(8'h20));
                chk("refill consumed", 64'(recargas_rest), 64'(4'd0));
            end
            if (vt[i].op == OP_HOLD) begin
                ch_garrafa = 1'b1; idle(vt[i].n); ch_garrafa = 1'b0; step();
            end else begin
                press(vt[i].op, vt[i].n);
            end
            idle(8);
            chk($sformatf("vec%0d rolhas", i),   64'(rolhas_bcd),    64'(vt[i].rol));
            chk($sformatf("vec%0d duzias", i),   64'(duzias_bcd),    64'(vt[i].duz));
            chk($sformatf("vec%0d recargas", i), 64'(recargas_rest), 64'(vt[i].rec));
            chk($sformatf("vec%0d vazia", i),    64'(rolha_vazia),   64'(vt[i].vaz));
            chk($sformatf("vec%0d estouro", i),  64'(estouro),       64'(vt[i].est));
            chk($sformatf("vec%0d recarr", i),   64'(recarregando),  64'(1'b0));
        end

        // Clear from exhausted/overflowed state, with a partial dozen pending.
        press(OP_GAR, 5);
        press(OP_ZERA, 1);
        idle(4);
        chk("zera rolhas",   64'(rolhas_bcd),    64'(8'h20));
        chk("zera duzias",   64'(duzias_bcd),    64'(8'h00));
        chk("zera recargas", 64'(recargas_rest), 64'(4'd1));
        chk("zera estouro",  64'(estouro),       64'(1'b0));

        // Clear in the middle of a refill: refill is dropped, refill budget restored.
        press(OP_ROL, 15);
        wait_refill();
        press(OP_ZERA, 1);
        chk("zera mid refill before", 64'(recarregando), 64'(1'b1));
        step();
        chk("zera mid refill recarr",   64'(recarregando),  64'(1'b0));
        chk("zera mid refill rolhas",   64'(rolhas_bcd),    64'(8'h20));
        chk("zera mid refill recargas", 64'(recargas_rest), 64'(4'd1));
        idle(6);
        chk("zera refill lost", 64'({recarregando, recargas_rest}), 64'({1'b0, 4'd1}));

        // Simultaneous cork and bottle event, landing on E+2.
        press(OP_GAR, 11);
        chk("simul pre duzias", 64'(duzias_bcd), 64'(8'h00));
        ch_rolha = 1'b1; ch_garrafa = 1'b1;
        step();
        ch_rolha = 1'b0; ch_garrafa = 1'b0;
        chk("simul E rolhas", 64'(rolhas_bcd), 64'(8'h20));
        step();
        chk("simul E+1", 64'({rolhas_bcd, duzias_bcd}), 64'({8'h20, 8'h00}));
        step();
        chk("simul E+2", 64'({rolhas_bcd, duzias_bcd}), 64'({8'h19, 8'h01}));

        // Display walk with duzias 01, rolhas 19.
        dig_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_exp = '{7'h3F, 7'h06, 7'h06, 7'h6F};
        n = 0;
        while (dig != 4'b1110 && n < 4 * RDIV) begin step(); n++; end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("display dig slot%0d", k), 64'(dig), 64'(dig_exp[k]));
            chk($sformatf("display seg slot%0d", k), 64'(seg), 64'(seg_exp[k]));
            idle(RDIV);
        end

        // Asynchronous reset in the middle of a refill.
        press(OP_ROL, 14);
        wait_refill();
        chk("rst pre refill", 64'(recarregando), 64'(1'b1));
        #2 rst = 1'b1;
        #1;
        m_full_reset();
        chk("rst mid refill recarr",   64'(recarregando),  64'(1'b0));
        chk("rst mid refill rolhas",   64'(rolhas_bcd),    64'(8'h20));
        chk("rst mid refill recargas", 64'(recargas_rest), 64'(4'd1));
        chk("rst mid refill duzias",   64'(duzias_bcd),    64'(8'h00));
        chk("rst mid refill display",  64'({dig, seg}),    64'({4'b1110, 7'h3F}));
        @(negedge clk);
        rst = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            ch_rolha   = 1'($urandom_range(0, 1));
            ch_garrafa = 1'($urandom_range(0, 1));
            ch_zera    = ($urandom_range(0, 149) == 0);
            step();
        end
        ch_rolha = 1'b0; ch_garrafa = 1'b0; ch_zera = 1'b0;
        idle(8);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
